// File: rtl/execute_pkg.sv
// Shared execute-stage types: multiply/divide opcodes, controller states and op decode helpers.
package execute_pkg;

    typedef enum logic [2:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MADD,
        MD_MADDU,
        MD_MSUB,
        MD_MSUBU
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_t;

    localparam int MD_CNT_W = 4;

    function automatic logic md_is_mul(input md_op_t op);
        return !(op == MD_DIV || op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT || op == MD_DIV || op == MD_MADD || op == MD_MSUB);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per step.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    assign rem_sh = {remainder, quotient[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            cnt       <= '0;
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= rem_sh[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply / multiply-accumulate / divide unit with a hold-count multiplier.
//
// state   | meaning
// IDLE    | waiting for start; results held
// MUL     | holding the product for MUL_LAT cycles
// DIV     | one restoring quotient bit per cycle
// FIX     | sign correction / divide-by-zero result, then done
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t              state;
    md_op_t                 op_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [MD_CNT_W-1:0]    cnt;
    logic                   neg_q;
    logic                   neg_r;
    logic                   div_zero;

    logic                   accept;
    logic                   in_signed;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_last;
    logic                   q_signed;
    logic [2*WIDTH-1:0]     ext_a;
    logic [2*WIDTH-1:0]     ext_b;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     mul_res;
    logic [WIDTH-1:0]       fix_hi;
    logic [WIDTH-1:0]       fix_lo;

    assign busy      = (state != ST_IDLE);
    assign accept    = (state == ST_IDLE) && start && !flush;
    assign in_signed = md_is_signed(op);
    assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept),
        .step      (state == ST_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (div_last)
    );

    // Extending both operands to 2*WIDTH lets one multiplier serve signed and unsigned ops.
    assign q_signed = md_is_signed(op_q);
    assign ext_a    = {{WIDTH{q_signed & a_q[WIDTH-1]}}, a_q};
    assign ext_b    = {{WIDTH{q_signed & b_q[WIDTH-1]}}, b_q};
    assign product  = ext_a * ext_b;

    always_comb begin
        mul_res = product;
        case (op_q)
            MD_MADD, MD_MADDU: mul_res = acc_q + product;
            MD_MSUB, MD_MSUBU: mul_res = acc_q - product;
            default:           mul_res = product;
        endcase
    end

    always_comb begin
        fix_lo = neg_q ? -quotient : quotient;
        fix_hi = neg_r ? -remainder : remainder;
        if (div_zero) begin
            fix_lo = '1;
            fix_hi = a_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            op_q     <= MD_MULT;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        a_q      <= a;
                        b_q      <= b;
                        acc_q    <= {hi_in, lo_in};
                        cnt      <= '0;
                        neg_q    <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= in_signed && a[WIDTH-1];
                        div_zero <= (b == '0);
                        if (md_is_mul(op))
                            state <= ST_MUL;
                        else if (b == '0)
                            state <= ST_FIX;
                        else
                            state <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == MD_CNT_W'(MUL_LAT - 1)) begin
                        {hi, lo} <= mul_res;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + MD_CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (flush)
                        state <= ST_IDLE;
                    else if (div_last)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: results, latencies, flush, held start and async reset.
module tb_muldiv_iter;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    md_op_t      op = MD_MULT;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi_in = '0;
    logic [31:0] lo_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int ndone;

    muldiv_iter #(.WIDTH(32), .MUL_LAT(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents the operation for exactly one rising edge (edge 0); returns 1 ns after it.
    task automatic issue(input md_op_t o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ihi, input logic [31:0] ilo);
        @(negedge clk);
        op = o; a = ia; b = ib; hi_in = ihi; lo_in = ilo;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int l);
        l = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2 resetn = 1'b0;
        #10;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        chk("mult_busy", 64'(busy), 64'd1);
        wait_done(10, lat);
        chk("mult_lat", 64'(lat), 64'd3);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        wait_done(10, lat);
        chk("maddu_lat", 64'(lat), 64'd3);
        chk("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

        issue(MD_MSUB, 32'd3, 32'd4, 32'd0, 32'd10);
        wait_done(10, lat);
        chk("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_done(10, lat);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(MD_MADD, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd5);
        wait_done(10, lat);
        chk("madd_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        wait_done(50, lat);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MD_DIVU, 32'd100, 32'd0, 32'd0, 32'd0);
        wait_done(50, lat);
        chk("divz_lat", 64'(lat), 64'd1);
        chk("divz_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_done(50, lat);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0);
        wait_done(50, lat);
        chk("div_negdsr_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        chk("b2b_idle", 64'(busy), 64'd0);

        issue(MD_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
        chk("b2b_accept", 64'(busy), 64'd1);
        wait_done(50, lat);
        chk("divu_lat", 64'(lat), 64'd33);
        chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        issue(MD_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        count_done(40, ndone);
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        @(negedge clk);
        op = MD_MULT; a = 32'd7; b = 32'hFFFF_FFFD; hi_in = '0; lo_in = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd100;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (k == 3) begin
                chk("held_done_lat", 64'(done), 64'd1);
                start = 1'b0;
            end
        end
        chk("held_one_done", 64'(ndone), 64'd1);
        chk("held_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        @(negedge clk);
        op = MD_MULT; a = 32'd5; b = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("fs_busy", 64'(busy), 64'd0);
        count_done(6, ndone);
        chk("fs_no_done", 64'(ndone), 64'd0);
        chk("fs_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        issue(MD_DIV, 32'd50, 32'd5, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        count_done(40, ndone);
        chk("rst_no_done", 64'(ndone), 64'd0);
        chk("rst_hilo_after", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
